// File: rtl/prisoner_seeker.sv
// Loop-strategy seeker: walks box pointers from box[prisoner_id] until it finds its own id,
// hits an illegal pointer, or runs out of opens. Define SEEKER_ABORT_EN to add the abort input.
module prisoner_seeker #(
   parameter int NUM_BOXES = 100,
   parameter int MAX_OPENS = 50,
   parameter int DATA_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] prisoner_id,
`ifdef SEEKER_ABORT_EN
   input  logic              abort,
`endif
   output logic [2:0]        box_state,
   output logic [DATA_W-1:0] box_sel,
   input  logic [DATA_W-1:0] box_data,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic              err,
   output logic [7:0]        opens_used
);

   typedef enum logic [1:0] {IDLE, OPEN, READ, FINISH} state_t;

   localparam logic [2:0]        ST_IDLE = 3'b000;
   localparam logic [2:0]        ST_OUT  = 3'b010;
   localparam logic [DATA_W:0]   NB      = NUM_BOXES[DATA_W:0];
   localparam logic [7:0]        MAXO    = MAX_OPENS[7:0];

   state_t            state_q;
   logic [DATA_W-1:0] id_q, sel_q;
   logic [2:0]        bst_q;
   logic              busy_q, done_q, found_q, err_q;
   logic [7:0]        opens_q;
   logic              abort_w;

`ifdef SEEKER_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   function automatic logic legal(input logic [DATA_W-1:0] v);
      return ({1'b0, v} < NB);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         id_q    <= '0;
         sel_q   <= '0;
         bst_q   <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         found_q <= 1'b0;
         err_q   <= 1'b0;
         opens_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  found_q <= 1'b0;
                  opens_q <= '0;
                  if (legal(prisoner_id)) begin
                     id_q    <= prisoner_id;
                     sel_q   <= prisoner_id;
                     err_q   <= 1'b0;
                     bst_q   <= ST_OUT;
                     busy_q  <= 1'b1;
                     state_q <= OPEN;
                  end else begin
                     err_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= FINISH;
                  end
               end
            end
            OPEN: begin
               // The open in progress is counted even when aborted here.
               opens_q <= opens_q + 8'd1;
               bst_q   <= ST_IDLE;
               if (abort_w) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FINISH;
               end else begin
                  state_q <= READ;
               end
            end
            READ: begin
               if (abort_w) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FINISH;
               end else if (box_data == id_q) begin
                  found_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FINISH;
               end else if (!legal(box_data)) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FINISH;
               end else if (opens_q == MAXO) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FINISH;
               end else begin
                  sel_q   <= box_data;
                  bst_q   <= ST_OUT;
                  state_q <= OPEN;
               end
            end
            FINISH: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign box_state  = bst_q;
   assign box_sel    = sel_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign found      = found_q;
   assign err        = err_q;
   assign opens_used = opens_q;

endmodule

// File: tb/tb_prisoner_seeker.sv
// Scoreboard bench for prisoner_seeker: a behavioural box row answers the command bus, a loop-walk
// model queues expected box selects and results, and a negedge monitor pops and compares them.
module tb_prisoner_seeker;
   localparam int NB = 8, MO = 4, DW = 8;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [DW-1:0] prisoner_id = '0, box_data = '0, box_sel;
   logic [2:0]    box_state;
   logic          busy, done, found, err;
   logic [7:0]    opens_used;
`ifdef SEEKER_ABORT_EN
   logic          abort = 1'b0;
`endif

   logic [DW-1:0] boxes [256];
   int            cyc = 0;
   int            n_chk = 0, n_fail = 0;

   typedef struct {
      logic       found;
      logic       err;
      logic [7:0] opens;
      int         due;
   } res_t;
   res_t          res_q[$];
   logic [DW-1:0] sel_q[$];

   prisoner_seeker #(.NUM_BOXES(NB), .MAX_OPENS(MO), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .prisoner_id(prisoner_id),
`ifdef SEEKER_ABORT_EN
      .abort(abort),
`endif
      .box_state(box_state), .box_sel(box_sel), .box_data(box_data),
      .busy(busy), .done(done), .found(found), .err(err), .opens_used(opens_used)
   );

   always #5 clk = ~clk;

   // Box row: selected box registers its content when commanded to output.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (box_state == 3'b010) box_data <= boxes[box_sel];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (box_state == 3'b010) begin
            chk("sel_pending", 32'(sel_q.size() > 0), 32'd1);
            if (sel_q.size() > 0) chk("box_sel", 32'(box_sel), 32'(sel_q.pop_front()));
         end
         if (done) begin
            chk("res_pending", 32'(res_q.size() > 0), 32'd1);
            if (res_q.size() > 0) begin
               res_t r;
               r = res_q.pop_front();
               chk("found", 32'(found), 32'(r.found));
               chk("err", 32'(err), 32'(r.err));
               chk("opens_used", 32'(opens_used), 32'(r.opens));
               chk("latency", cyc, r.due);
            end
         end
      end
   end

   task automatic model(input logic [DW-1:0] id, input int t0);
      res_t r;
      logic [DW-1:0] cur, d;
      r.found = 1'b0; r.err = 1'b0; r.opens = '0;
      if (id >= NB) begin
         r.err = 1'b1;
         r.due = t0 + 1;
      end else begin
         cur = id;
         for (int k = 1; k <= MO; k++) begin
            sel_q.push_back(cur);
            d = boxes[cur];
            r.opens = 8'(k);
            if (d == id) begin r.found = 1'b1; break; end
            if (d >= NB) begin r.err = 1'b1; break; end
            cur = d;
         end
         r.due = t0 + 1 + 2 * int'(r.opens);
      end
      res_q.push_back(r);
   endtask

   task automatic launch(input logic [DW-1:0] id);
      @(posedge clk); #1;
      start = 1'b1; prisoner_id = id;
      model(id, cyc);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && res_q.size() != 0; i++) @(posedge clk);
      chk("timeout", 32'(res_q.size()), 32'd0);
      res_q.delete(); sel_q.delete();
      @(posedge clk);
   endtask

   task automatic run(input logic [DW-1:0] id);
      launch(id);
      wait_idle();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) boxes[i] = '0;
      #12;
      chk("rst_state", 32'(box_state), 32'd0);
      chk("rst_sel", 32'(box_sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_found", 32'(found), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_opens", 32'(opens_used), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Short loop 0->3->5->0 found in three opens.
      boxes[0] = 8'd3; boxes[3] = 8'd5; boxes[5] = 8'd0;
      run(8'd0);
      chk("s1_found_held", 32'(found), 32'd1);
      chk("s1_opens_held", 32'(opens_used), 32'd3);

      // Long loop exhausts the budget; a start while busy must be ignored.
      boxes[1] = 8'd2; boxes[2] = 8'd4; boxes[4] = 8'd6; boxes[6] = 8'd7; boxes[7] = 8'd1;
      launch(8'd1);
      @(posedge clk); #1;
      chk("busy_mid", 32'(busy), 32'd1);
      start = 1'b1; prisoner_id = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();
      chk("s2_found_held", 32'(found), 32'd0);
      chk("s2_opens_held", 32'(opens_used), 32'd4);

      // Self-pointing box, illegal id, illegal content.
      boxes[2] = 8'd2;
      run(8'd2);
      run(8'd9);
      chk("s4_err_held", 32'(err), 32'd1);
      boxes[0] = 8'd12;
      run(8'd0);
      chk("s4_content_err", 32'(err), 32'd1);
      chk("s4_content_opens", 32'(opens_used), 32'd1);

      // Async reset during the second READ aborts silently.
      boxes[0] = 8'd3;
      launch(8'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", 32'(box_state), 32'd0);
      chk("arst_sel", 32'(box_sel), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_opens", 32'(opens_used), 32'd0);
      chk("arst_found", 32'(found), 32'd0);
      res_q.delete(); sel_q.delete();
      @(posedge clk); #1;
      chk("arst_no_done", 32'(done), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      run(8'd0);

      // Random rows, including illegal contents and ids.
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < NB; i++) boxes[i] = 8'($urandom_range(0, 9));
         run(8'($urandom_range(0, 9)));
      end

`ifdef SEEKER_ABORT_EN
      begin
         res_t r;
         int t0;
         boxes[0] = 8'd3; boxes[3] = 8'd5; boxes[5] = 8'd0;
         @(posedge clk); #1;
         start = 1'b1; prisoner_id = 8'd0; t0 = cyc;
         sel_q.push_back(8'd0); sel_q.push_back(8'd3);
         r.found = 1'b0; r.err = 1'b1; r.opens = 8'd2; r.due = t0 + 4;
         res_q.push_back(r);
         @(posedge clk); #1; start = 1'b0;
         repeat (2) @(posedge clk);
         #1 abort = 1'b1;
         @(posedge clk); #1 abort = 1'b0;
         wait_idle();
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/prisoner_seeker.md
Name: prisoner_seeker

Overview:
Initiator side of the prisoner_box interface. Given a prisoner number, it walks the loop strategy over a row of boxes:
- open box[prisoner_id] and read its content;
- jump to the box named by that content;
- repeat until the content equals prisoner_id or the open budget is exhausted.

It drives the box command bus (state code plus box select) and consumes the selected box's registered output. It never loads boxes and never presents a guard key.

Parameters:
- NUM_BOXES, 100, number of boxes; legal ids and contents are 0..NUM_BOXES-1.
- MAX_OPENS, 50, maximum boxes one prisoner may open (1..255).
- DATA_W, 8, width of box ids, contents, prisoner_id and box_sel.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a search; sampled only in IDLE.
- prisoner_id  in  DATA_W  prisoner number; latched when start is accepted.
- box_state  out  3  box command: 3'b000 idle, 3'b010 output; 3'b001/3'b100 never driven.
- box_sel  out  DATA_W  index of the box being opened; external mux routes it.
- box_data  in  DATA_W  output_data of the selected box.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a search ends.
- found  out  1  result; valid with done, held until the next accepted start.
- err  out  1  illegal id or content encountered; valid with done, held until the next accepted start.
- opens_used  out  8  number of boxes opened in the last search; held until the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state IDLE; box_state=000, box_sel=0, busy=0, done=0, found=0, err=0, opens_used=0; latched id cleared. Reset mid-search aborts it immediately, with no done pulse.
- Clock and reset are fixed as stated: one clock, asynchronous active-low reset.
- FSM states: IDLE, OPEN, READ, FINISH.
- IDLE:
  - start=1 with prisoner_id < NUM_BOXES: latch id; box_sel <= prisoner_id; found, err, opens_used cleared; go to OPEN.
  - start=1 with prisoner_id >= NUM_BOXES: err <= 1, found <= 0, opens_used <= 0; go to FINISH.
  - start while not IDLE is ignored.
- OPEN (1 cycle): box_state=010, box_sel stable; opens_used increments at the end of the cycle; go to READ.
- READ (1 cycle): box_state=000. The box registered its data at the OPEN edge, so box_data is valid throughout READ and is sampled at the end of READ. Priority at the end of READ:
  1. box_data == latched id: found <= 1, go to FINISH.
  2. box_data >= NUM_BOXES: err <= 1, go to FINISH.
  3. opens_used == MAX_OPENS: found <= 0, go to FINISH.
  4. Otherwise box_sel <= box_data, go to OPEN.
- Match takes priority over budget: a match on the last permitted open reports found=1.
- FINISH (1 cycle): done=1, busy=0, box_state=000; go to IDLE. start is not accepted in this cycle.
- Latency: k opens from start accepted to done pulse = 2k+1 cycles; an illegal id gives done 1 cycle after start.
- Content 0 (a cleared box) is a legal pointer to box 0.
- box_sel holds its last value in IDLE.
- box_state is only ever 000 or 010, so box contents are never modified.

Optional Feature:
- SEEKER_ABORT_EN defined: adds input abort (1 bit). abort=1 sampled in OPEN or READ sends the FSM to FINISH on that edge with found=0 and err=1. opens_used keeps its count, including the open in progress if abort lands in OPEN. abort is ignored in IDLE and FINISH.
- Not defined: no abort port, and searches always run to a match, an error, or budget exhaustion.

Test Plan:
1. NUM_BOXES=8, MAX_OPENS=4; boxes {0:3, 3:5, 5:0}; start with prisoner_id=0 -> box_sel sequence 0, 3, 5; done 7 cycles after start; found=1, err=0, opens_used=3.
2. Same setup; loop 1->2, 2->4, 4->6, 6->7, 7->1; prisoner_id=1 -> boxes 1, 2, 4, 6 opened; done with found=0, opens_used=4; box 7 never selected.
3. Box 2 content 2; prisoner_id=2 -> single open; done 3 cycles after start; found=1, opens_used=1.
4. prisoner_id=9 (NUM_BOXES=8) -> done 1 cycle after start; err=1, found=0, opens_used=0. Box 0 content 12, prisoner_id=0 -> err=1 after 1 open.
5. Assert rst_n=0 during the second READ of scenario 1 -> all outputs 0 asynchronously with no done pulse; a new start afterwards completes normally. Start pulsed while busy is ignored.
6. SEEKER_ABORT_EN defined: abort=1 in the second OPEN of scenario 1 -> done on the next cycle; found=0, err=1, opens_used=2.
